// File: rtl/cpu.sv
// Multi-cycle 16-bit accumulator CPU: FETCH -> EXECUTE -> (LOAD) -> ALU -> FETCH.
// Define CPU_SHIFT_EN to enable the serial B shifter for format-10 instructions.
module cpu (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] address,
  output logic [15:0] data_out,
  input  logic [15:0] data_in,
  output logic        wren_n,
  output logic        oen_n
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    EXECUTE = 3'd1,
    LOAD    = 3'd2,
    ALU     = 3'd3
  } state_t;

  state_t      state, next_state;
  logic [15:0] pc, a, b, op;
  logic [3:0]  cnt;
  logic [15:0] res;
  logic        jump;

  logic signed [7:0]  lit8;
  logic signed [15:0] lit_sext;

  function automatic logic [15:0] alu_f(input logic [2:0] fn,
                                        input logic [15:0] x,
                                        input logic [15:0] y);
    case (fn)
      3'b000:  alu_f = x + y;
      3'b001:  alu_f = x - y;
      3'b010:  alu_f = x | y;
      3'b011:  alu_f = x & y;
      3'b100:  alu_f = x ^ y;
      3'b101:  alu_f = y;
      3'b110:  alu_f = x;
      default: alu_f = 16'h0000;
    endcase
  endfunction

  assign lit8     = op[7:0];
  assign lit_sext = 16'(lit8);
  assign res      = alu_f(op[11:9], a, b);
  assign jump     = op[15] && (op[13:12] == 2'b11);

  always_comb begin
    next_state = state;
    address    = pc;
    data_out   = a;
    wren_n     = 1'b1;
    oen_n      = 1'b1;
    case (state)
      FETCH: begin
        oen_n      = 1'b0;
        next_state = EXECUTE;
      end
      EXECUTE: begin
        next_state = ALU;
        if (op[15:13] == 3'b010) begin
          address = b;
          wren_n  = 1'b0;
        end else if (op[15:13] == 3'b011) begin
          next_state = LOAD;
        end
      end
      LOAD: begin
        address    = b;
        oen_n      = 1'b0;
        next_state = ALU;
      end
      ALU: begin
        if (cnt == 4'd0) next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= 16'h0000;
      a     <= 16'h0000;
      b     <= 16'h0000;
      op    <= 16'h0000;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      case (state)
        FETCH: op <= data_in;
        EXECUTE: begin
          case (op[15:14])
            2'b00: b <= {2'b00, op[13:0]};
            2'b11: b <= lit_sext;
            2'b10: begin
`ifdef CPU_SHIFT_EN
              cnt <= op[3:0];
`else
              cnt <= 4'd0;
`endif
            end
            default: ;
          endcase
        end
        LOAD: b <= data_in;
        ALU: begin
          if (cnt != 4'd0) begin
            // one bit per cycle; the ALU result is taken only once cnt reaches 0
            b   <= op[4] ? (b >> 1) : (b << 1);
            cnt <= cnt - 4'd1;
          end else begin
            if (op[15]) begin
              case (op[13:12])
                2'b01:   a  <= res;
                2'b10:   b  <= res;
                2'b11:   pc <= res;
                default: ;
              endcase
            end
            if (!jump) pc <= pc + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: instruction-level model predicts every memory-bus cycle; memory modelled in the bench.
module tb_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] address, data_out, data_in;
  logic        wren_n, oen_n;

  always #5 clk = ~clk;

  cpu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .address  (address),
    .data_out (data_out),
    .data_in  (data_in),
    .wren_n   (wren_n),
    .oen_n    (oen_n)
  );

`ifdef CPU_SHIFT_EN
  localparam bit SHIFT_ON = 1'b1;
`else
  localparam bit SHIFT_ON = 1'b0;
`endif

  logic [15:0] mem  [65536];
  logic [15:0] mmem [65536];

  assign data_in = mem[address];
  always @(posedge clk) if (!wren_n) mem[address] <= data_out;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] dout;
    logic        wr_n;
    logic        oe_n;
  } bus_t;

  bus_t        exp_q[$];
  logic [15:0] ma, mb, mpc;
  int          k;
  int          errors = 0;
  int          checks = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] ad, input logic wr, input logic oe);
    bus_t e;
    e.addr = ad; e.dout = ma; e.wr_n = wr; e.oe_n = oe;
    exp_q.push_back(e);
  endtask

  function automatic logic [15:0] alu_model(input logic [2:0] fn, input logic [15:0] x, input logic [15:0] y);
    case (fn)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x | y;
      3'd3: return x & y;
      3'd4: return x ^ y;
      3'd5: return y;
      3'd6: return x;
      default: return 16'h0000;
    endcase
  endfunction

  // Executes one instruction on the model and queues the bus cycles it must produce.
  task automatic model_instr();
    logic [15:0] ir, res;
    int n;
    ir = mmem[mpc];
    push(mpc, 1'b1, 1'b0);
    if (ir[15:13] == 3'b010) begin
      push(mb, 1'b0, 1'b1);
      mmem[mb] = ma;
      push(mpc, 1'b1, 1'b1);
      mpc = mpc + 16'd1;
    end else if (ir[15:13] == 3'b011) begin
      push(mpc, 1'b1, 1'b1);
      push(mb, 1'b1, 1'b0);
      mb = mmem[mb];
      push(mpc, 1'b1, 1'b1);
      mpc = mpc + 16'd1;
    end else if (ir[15:14] == 2'b00) begin
      push(mpc, 1'b1, 1'b1);
      mb = {2'b00, ir[13:0]};
      push(mpc, 1'b1, 1'b1);
      mpc = mpc + 16'd1;
    end else begin
      push(mpc, 1'b1, 1'b1);
      if (ir[15:14] == 2'b11) mb = {{8{ir[7]}}, ir[7:0]};
      n = (ir[15:14] == 2'b10 && SHIFT_ON) ? int'(ir[3:0]) : 0;
      if (n > 0) mb = ir[4] ? (mb >> n) : (mb << n);
      repeat (n + 1) push(mpc, 1'b1, 1'b1);
      res = alu_model(ir[11:9], ma, mb);
      case (ir[13:12])
        2'b01: ma = res;
        2'b10: mb = res;
        2'b11: mpc = res;
        default: ;
      endcase
      if (ir[13:12] != 2'b11) mpc = mpc + 16'd1;
    end
    k++;
    case (k)
      2:  begin check("pin_a_k2", ma, 16'hFFFF); check("pin_b_k2", mb, 16'hFFFF); check("pin_pc_k2", mpc, 16'h0002); end
      8:  check("pin_load_b", mb, 16'hBEEF);
      15: begin check("pin_a_xor", ma, 16'h0055); check("pin_b_mov", mb, 16'h0055); end
      25: check("pin_shift_r", mb, SHIFT_ON ? 16'h0010 : 16'h0043);
      27: check("pin_jump_pc", mpc, 16'h0100);
      29: begin check("pin_wrap_pc", mpc, 16'h0000); check("pin_wrap_b", mb, 16'h0007); end
      default: ;
    endcase
  endtask

  task automatic compare_cycle();
    bus_t e, act;
    if (exp_q.size() == 0) model_instr();
    e = exp_q.pop_front();
    act = {address, data_out, wren_n, oen_n};
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL bus k=%0d: got addr=%h dout=%h wr_n=%b oe_n=%b expected addr=%h dout=%h wr_n=%b oe_n=%b",
               k, act.addr, act.dout, act.wr_n, act.oe_n, e.addr, e.dout, e.wr_n, e.oe_n);
    end
    checks++;
    if (!(wren_n | oen_n)) begin
      errors++;
      $display("FAIL strobes: got wren_n=%b oen_n=%b expected not both 0", wren_n, oen_n);
    end
  endtask

  task automatic run(input int target);
    for (int c = 0; c < 4000; c++) begin
      if (k >= target && exp_q.size() == 0) return;
      if (c > 0) @(negedge clk);
      #1;
      compare_cycle();
    end
    errors++;
    $display("FAIL run_budget: got k=%0d expected %0d", k, target);
  endtask

  task automatic put(input logic [15:0] ad, input logic [15:0] v);
    mem[ad] = v;
    mmem[ad] = v;
  endtask

  initial begin
    logic [15:0] prog [27];
    bit found;
    prog = '{16'h1234, 16'hD1FF, 16'h00AA, 16'h9A00, 16'h0040, 16'h4000, 16'h0050,
             16'h6000, 16'h9A00, 16'h0041, 16'h4000, 16'hD2FF, 16'hD4F0, 16'hD60F,
             16'hD855, 16'hEC00, 16'hCE00, 16'h0042, 16'h4000, 16'h0001, 16'hAA03,
             16'h9A00, 16'h0043, 16'h4000, 16'hAA12, 16'h0100, 16'hBA00};
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 16'h0000;
      mmem[i] = 16'h0000;
    end
    for (int i = 0; i < 27; i++) put(16'(i), prog[i]);
    put(16'h0050, 16'hBEEF);
    put(16'h0100, 16'hFAFF);
    put(16'hFFFF, 16'h0007);

    ma = '0; mb = '0; mpc = '0; k = 0;
    repeat (3) @(negedge clk);
    check("rst_address", address, 16'h0000);
    check("rst_oen_n", {15'd0, oen_n}, 16'h0000);
    check("rst_wren_n", {15'd0, wren_n}, 16'h0001);

    rst_n = 1'b1;
    run(34);

    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!wren_n) begin
        found = 1'b1;
        break;
      end
    end
    check("store_seen", {15'd0, found}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("abort_wren_n", {15'd0, wren_n}, 16'h0001);
    check("abort_oen_n", {15'd0, oen_n}, 16'h0000);
    check("abort_address", address, 16'h0000);
    check("abort_data_out", data_out, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    ma = '0; mb = '0; mpc = '0; k = 100;
    exp_q.delete();
    run(103);

    check("mem_40", mem[16'h0040], 16'h00AA);
    check("mem_41", mem[16'h0041], 16'hBEEF);
    check("mem_42", mem[16'h0042], 16'h0055);
    check("mem_43", mem[16'h0043], SHIFT_ON ? 16'h0008 : 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
